// File: rtl/mux_pkg.sv
// Shared constants and types for the arbitrated mux.
// Imported by the arbiter and the top-level register stage.
package mux_pkg;
  localparam int MUX_WIDTH_DEF = 5;
  localparam int MUX_NCH_DEF = 4;

  typedef enum logic {
    ARB_FIXED,
    ARB_RR
  } arb_mode_e;
endpackage

// File: rtl/rr_arbiter.sv
// Combinational arbiter: fixed priority from index 0,
// or round-robin search starting at ptr.
module rr_arbiter
  import mux_pkg::*;
#(
  parameter int NCH = MUX_NCH_DEF,
  localparam int IDXW = $clog2(NCH)
) (
  input  logic [NCH-1:0]  req,
  input  logic [IDXW-1:0] ptr,
  input  arb_mode_e       mode,
  output logic [NCH-1:0]  grant,
  output logic [IDXW-1:0] winner_idx,
  output logic            any
);

  logic [IDXW-1:0] start;
  logic [IDXW:0]   sum;
  logic [IDXW-1:0] idx;

  assign start = (mode == ARB_RR) ? ptr : '0;

  always_comb begin
    grant = '0;
    winner_idx = '0;
    any = 1'b0;
    sum = '0;
    idx = '0;
    for (int i = 0; i < NCH; i++) begin
      // Both terms are below NCH, so one subtract wraps
      sum = {1'b0, start} + (IDXW+1)'(i);
      if (sum >= (IDXW+1)'(NCH))
        sum = sum - (IDXW+1)'(NCH);
      idx = sum[IDXW-1:0];
      if (!any && req[idx]) begin
        any = 1'b1;
        grant[idx] = 1'b1;
        winner_idx = idx;
      end
    end
  end

endmodule

// File: rtl/arb_mux_reg.sv
// N-channel arbitrated mux with valid/ready handshake
// and a single registered output stage.
module arb_mux_reg
  import mux_pkg::*;
#(
  parameter int WIDTH = MUX_WIDTH_DEF,
  parameter int NCH = MUX_NCH_DEF,
  localparam int IDXW = $clog2(NCH)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 mode_rr,
  input  logic [NCH-1:0]       in_valid,
  input  logic [NCH*WIDTH-1:0] in_data,
  output logic [NCH-1:0]       in_ready,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIDTH-1:0]     out_data,
  output logic [IDXW-1:0]      out_sel
);

  logic [IDXW-1:0]  ptr_q, ptr_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic [IDXW-1:0]  out_sel_q, out_sel_d;

  logic [NCH-1:0]  grant;
  logic [IDXW-1:0] winner;
  logic            any;
  logic            load_en;
  logic            xfer;
  arb_mode_e       mode;

  assign mode = arb_mode_e'(mode_rr);

  rr_arbiter #(.NCH(NCH)) u_arb (
    .req        (in_valid),
    .ptr        (ptr_q),
    .mode       (mode),
    .grant      (grant),
    .winner_idx (winner),
    .any        (any)
  );

  assign load_en = !out_valid_q | out_ready;
  assign xfer = load_en & any;
  // Held off during reset even though the stage looks empty
  assign in_ready = grant & {NCH{load_en & rst_n}};

  always_comb begin
    ptr_d = ptr_q;
    out_valid_d = out_valid_q;
    out_data_d = out_data_q;
    out_sel_d = out_sel_q;
    if (xfer) begin
      out_valid_d = 1'b1;
      out_data_d = in_data[int'(winner)*WIDTH +: WIDTH];
      out_sel_d = winner;
      if (mode == ARB_RR) begin
        if (winner == IDXW'(NCH-1))
          ptr_d = '0;
        else
          ptr_d = winner + 1'b1;
      end
    end else if (load_en) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= '0;
      out_valid_q <= 1'b0;
      out_data_q <= '0;
      out_sel_q <= '0;
    end else begin
      ptr_q <= ptr_d;
      out_valid_q <= out_valid_d;
      out_data_q <= out_data_d;
      out_sel_q <= out_sel_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data = out_data_q;
  assign out_sel = out_sel_q;

endmodule

// File: tb/tb_arb_mux_reg.sv
// Directed bench for arb_mux_reg: reset, fixed priority,
// round-robin rotation, backpressure, wrap and async reset.
module tb_arb_mux_reg;
  localparam int W = 5;
  localparam int N = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         mode_rr;
  logic [N-1:0] in_valid;
  logic [N*W-1:0] in_data;
  logic [N-1:0] in_ready;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_data;
  logic [1:0]   out_sel;

  int n_chk = 0;
  int n_fail = 0;

  arb_mux_reg dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .mode_rr   (mode_rr),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_sel   (out_sel)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  task automatic edge1();
    @(posedge clk);
    #1;
  endtask

  task automatic set_seq();
    for (int i = 0; i < N; i++)
      in_data[i*W +: W] = W'(i + 1);
  endtask

  initial begin
    rst_n = 1'b0;
    mode_rr = 1'b0;
    in_valid = 4'hF;
    in_data = '0;
    set_seq();
    out_ready = 1'b1;

    edge1();
    edge1();
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_out_data", 32'(out_data), 0);
    chk("rst_out_sel", 32'(out_sel), 0);
    chk("rst_in_ready", 32'(in_ready), 0);

    rst_n = 1'b1;
    #1;
    chk("rel_in_ready", 32'(in_ready), 32'h1);
    edge1();
    chk("rel_out_valid", 32'(out_valid), 1);
    chk("rel_out_data", 32'(out_data), 1);
    chk("rel_out_sel", 32'(out_sel), 0);

    // Fixed priority: ch1 beats ch3
    in_valid = 4'b1010;
    in_data[1*W +: W] = 5'h11;
    in_data[3*W +: W] = 5'h1F;
    #1;
    chk("fix_in_ready", 32'(in_ready), 32'b0010);
    edge1();
    chk("fix_out_data", 32'(out_data), 32'h11);
    chk("fix_out_sel", 32'(out_sel), 1);
    chk("fix_in_ready2", 32'(in_ready), 32'b0010);
    edge1();
    chk("fix_out_sel2", 32'(out_sel), 1);

    // Round-robin from ptr 0 (fixed mode left it alone)
    mode_rr = 1'b1;
    in_valid = 4'hF;
    set_seq();
    for (int k = 0; k < 5; k++) begin
      #1;
      chk("rr_in_ready", 32'(in_ready),
          32'(1 << (k % 4)));
      edge1();
      chk("rr_out_sel", 32'(out_sel), 32'(k % 4));
      chk("rr_out_data", 32'(out_data),
          32'((k % 4) + 1));
    end

    // ptr is 1: load 5'h07 from ch1, ptr -> 2
    in_valid = 4'b0010;
    in_data[1*W +: W] = 5'h07;
    edge1();
    chk("bp_load", 32'(out_data), 32'h07);

    out_ready = 1'b0;
    in_valid = 4'hF;
    set_seq();
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("bp_in_ready", 32'(in_ready), 0);
      edge1();
      chk("bp_hold_data", 32'(out_data), 32'h07);
      chk("bp_hold_valid", 32'(out_valid), 1);
    end

    // Same-cycle drain and reload, grant ch2
    out_ready = 1'b1;
    #1;
    chk("bp_reload_rdy", 32'(in_ready), 32'b0100);
    edge1();
    chk("bp_reload_data", 32'(out_data), 3);
    chk("bp_reload_sel", 32'(out_sel), 2);
    chk("bp_reload_vld", 32'(out_valid), 1);

    // ptr is 3: only ch1 valid wraps around to it
    in_valid = 4'b0010;
    in_data[1*W +: W] = 5'h0A;
    #1;
    chk("wrap_in_ready", 32'(in_ready), 32'b0010);
    edge1();
    chk("wrap_out_sel", 32'(out_sel), 1);
    chk("wrap_out_data", 32'(out_data), 32'h0A);

    in_valid = 4'b0000;
    #1;
    chk("idle_in_ready", 32'(in_ready), 0);
    edge1();
    chk("idle_out_valid", 32'(out_valid), 0);
    edge1();
    chk("idle_out_valid2", 32'(out_valid), 0);
    chk("idle_data_hold", 32'(out_data), 32'h0A);
    chk("idle_sel_hold", 32'(out_sel), 1);

    // ptr should still be 2: ch2 beats ch0
    in_valid = 4'b0101;
    #1;
    chk("ptr_kept", 32'(in_ready), 32'b0100);
    edge1();
    chk("ptr_kept_sel", 32'(out_sel), 2);

    // ptr 3 -> grant ch1 -> ptr 2, then stall
    in_valid = 4'b0010;
    edge1();
    chk("pre_rst_sel", 32'(out_sel), 1);
    out_ready = 1'b0;
    in_valid = 4'hF;
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_out_valid", 32'(out_valid), 0);
    chk("arst_out_data", 32'(out_data), 0);
    chk("arst_in_ready", 32'(in_ready), 0);
    #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    #1;
    chk("arst_rel_rdy", 32'(in_ready), 32'b0001);
    edge1();
    chk("arst_rel_sel", 32'(out_sel), 0);
    chk("arst_rel_data", 32'(out_data), 1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
